// File: rtl/axi_master_bridge.sv
// axi_master_bridge: core-side AXI4 master engine. Accepts one requester
// transaction at a time and turns it into an INCR read burst (AR/R) or a
// single-beat write (AW/W/B). Read beats and write completions go back to
// the requester. AXI ordering/ID violations raise a sticky proto_err.
//
// Handshake semantics: a transfer happens on a rising clk edge where the
// source's valid and the sink's ready are both high. Every AXI valid here
// depends only on registered state, so it never depends combinationally on
// its own ready. Payload comes from registers captured at request accept
// and stays stable while valid is high.
module axi_master_bridge #(
  parameter logic [3:0] MASTER_ID = 4'd0,
  parameter int         DATA_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  // requester side
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [3:0]             req_len,
  input  logic [DATA_BITS-1:0]   req_wdata,
  input  logic [DATA_BITS/8-1:0] req_wstrb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_BITS-1:0]   rsp_data,
  output logic                   rsp_last,
  output logic                   rsp_err,
  output logic                   wr_done,
  output logic                   wr_err,
  output logic                   proto_err,
  // AXI read address channel
  output logic                   arvalid,
  input  logic                   arready,
  output logic [3:0]             arid,
  output logic [31:0]            araddr,
  output logic [3:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  // AXI read data channel
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [3:0]             rid,
  input  logic [DATA_BITS-1:0]   rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  // AXI write address channel
  output logic                   awvalid,
  input  logic                   awready,
  output logic [3:0]             awid,
  output logic [31:0]            awaddr,
  output logic [3:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  // AXI write data channel
  output logic                   wvalid,
  input  logic                   wready,
  output logic [DATA_BITS-1:0]   wdata,
  output logic [DATA_BITS/8-1:0] wstrb,
  output logic                   wlast,
  // AXI write response channel
  input  logic                   bvalid,
  output logic                   bready,
  input  logic [3:0]             bid,
  input  logic [1:0]             bresp,
  // debug: current FSM state
  output logic [2:0]             fsm_state
);

  localparam int         STRB_BITS = DATA_BITS / 8;
  localparam logic [2:0] AXI_SIZE  = 3'($clog2(STRB_BITS));
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t                 state, state_next;
  logic [31:0]            addr_q;
  logic [3:0]             len_q;
  logic [DATA_BITS-1:0]   wdata_q;
  logic [STRB_BITS-1:0]   wstrb_q;
  logic                   aw_done, w_done;
  // 5 bits so a 16-beat burst (len 15) counts to 16 without wrapping
  logic [4:0]             beat_cnt;
  logic                   r_hs;
  logic                   last_expected;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and channel valid/ready generation
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_write ? WR_ADDR : RD_ADDR;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        rready = rsp_ready;
        // A missing RLAST keeps us here until it finally arrives
        if (rvalid && rsp_ready && rlast) state_next = IDLE;
      end
      WR_ADDR: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        // Either channel may already be done, or both may finish together
        if ((aw_done || awready) && (w_done || wready)) state_next = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign r_hs          = rvalid && rready;
  assign last_expected = (beat_cnt == {1'b0, len_q});

  // Request capture, write-channel done flags, beat counter, sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      beat_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            len_q   <= req_write ? 4'd0 : req_len;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        RD_ADDR: begin
          if (arready) beat_cnt <= '0;
        end
        RD_DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 5'd1;
            if (rid != MASTER_ID)              proto_err <= 1'b1;
            if (rlast != last_expected)        proto_err <= 1'b1;
          end
        end
        WR_ADDR: begin
          if (awvalid && awready) aw_done <= 1'b1;
          if (wvalid && wready)   w_done  <= 1'b1;
        end
        WR_RESP: begin
          if (bvalid && bid != MASTER_ID) proto_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered AXI payloads
  assign arid    = MASTER_ID;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = AXI_SIZE;
  assign arburst = BURST_INCR;

  assign awid    = MASTER_ID;
  assign awaddr  = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = AXI_SIZE;
  assign awburst = BURST_INCR;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

  // Requester-facing read beat passthrough and write completion
  assign rsp_valid = (state == RD_DATA) && rvalid;
  assign rsp_data  = rdata;
  assign rsp_last  = rlast;
  assign rsp_err   = (rresp != 2'b00);
  assign wr_done   = (state == WR_RESP) && bvalid;
  assign wr_err    = wr_done && (bresp != 2'b00);

  assign fsm_state = state;

endmodule

// File: tb/tb_axi_master_bridge.sv
// tb_axi_master_bridge: randomized requester + AXI slave driver with a
// transaction-level reference model (expected beat queue, sticky error flag).
module tb_axi_master_bridge;

  localparam logic [3:0] MID = 4'd0;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
  logic [31:0] rsp_data;
  logic        wr_done, wr_err, proto_err;
  logic        arvalid, arready;
  logic [3:0]  arid, arlen;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid, awready;
  logic [3:0]  awid, awlen;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready, wlast;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  // entry = {last, err, data}
  logic [33:0] exp_q[$];
  bit          model_perr = 0;

  axi_master_bridge #(.MASTER_ID(MID), .DATA_BITS(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .wr_done(wr_done), .wr_err(wr_err), .proto_err(proto_err),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .fsm_state(fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave-side read data/response pattern for a given burst address and beat
  function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
    return (a * 32'h9e3779b1) ^ (32'(b) * 32'h01010101) ^ 32'h5a5a0000;
  endfunction

  function automatic logic [1:0] beat_resp(input logic [31:0] a, input int b);
    logic [3:0] k;
    k = a[7:4] + 4'(b);
    return (k % 5 == 0) ? 2'b10 : 2'b00;
  endfunction

  // Present one request in IDLE; returns at the negedge opening cycle T+1
  task automatic accept_req(input bit wr, input logic [31:0] a, input logic [3:0] l,
                            input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
    req_wdata = d; req_wstrb = s;
    #1;
    check("req_ready_idle", req_ready, 1);
    @(negedge clk);
    // scramble so any use of unregistered request fields shows up
    req_valid = 1'b0; req_write = $urandom_range(0, 1);
    req_addr = $urandom(); req_len = 4'($urandom());
    req_wdata = $urandom(); req_wstrb = 4'($urandom());
  endtask

  // rr_mode: 0 = rsp_ready always high, 1 = toggling, 2 = random
  task automatic do_read(input logic [31:0] a, input logic [3:0] l, input int ar_delay,
                         input int last_beat, input bit bad_rid, input int rr_mode, input bit gaps);
    int  cyc = 0;
    int  sent = 0;
    bit  ar_seen = 0;
    bit  ar_prev;
    bit  rv_pending = 0;
    bit  done = 0;
    logic [33:0] e;
    exp_q.delete();
    for (int b = 0; b <= last_beat; b++)
      exp_q.push_back({(b == last_beat), (beat_resp(a, b) != 2'b00), beat_data(a, b)});
    if (last_beat != int'(l) || bad_rid) model_perr = 1;
    accept_req(1'b0, a, l, $urandom(), 4'($urandom()));
    while (!done && cyc < 400) begin
      ar_prev = ar_seen;
      arready = !ar_seen && (cyc >= ar_delay);
      if (ar_seen) begin
        if (!rv_pending) rv_pending = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        rvalid = rv_pending;
        rdata  = beat_data(a, sent);
        rresp  = beat_resp(a, sent);
        rlast  = (sent == last_beat);
        rid    = (bad_rid && sent == 0) ? (MID ^ 4'h5) : MID;
      end else begin
        rvalid = 1'b0; rlast = 1'b0; rdata = $urandom(); rid = 4'($urandom());
      end
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = (cyc % 2 == 0);
        default: rsp_ready = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      if (cyc == 0) check("arvalid_t1", arvalid, 1);
      if (!ar_seen) begin
        check("arvalid_held", arvalid, 1);
        check("araddr_stable", araddr, a);
        if (arvalid && arready) begin
          check("arlen", arlen, l);
          check("arsize", arsize, 3'd2);
          check("arburst", arburst, 2'b01);
          check("arid", arid, MID);
          ar_seen = 1;
        end
      end
      if (ar_prev) begin
        check("arvalid_dropped", arvalid, 0);
        check("rready_follows", rready, rsp_ready);
        check("rsp_valid_follows", rsp_valid, rvalid);
        if (rvalid && rready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_data, e[31:0]);
            check("rsp_err", rsp_err, e[32]);
            check("rsp_last", rsp_last, e[33]);
          end
          sent++;
          rv_pending = 0;
          if (rlast) done = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) check("read_timeout", 0, 1);
    rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
    #1;
    check("req_ready_after_read", req_ready, 1);
    check("beats_remaining", exp_q.size(), 0);
    check("proto_err_read", proto_err, model_perr);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_delay, input int w_delay, input int b_delay,
                          input logic [1:0] br, input bit bad_bid);
    int cyc = 0;
    int bwait = 0;
    bit aw_seen = 0, w_seen = 0, both;
    bit done = 0;
    bit aw_now, w_now;
    if (bad_bid) model_perr = 1;
    accept_req(1'b1, a, 4'($urandom()), d, s);
    while (!done && cyc < 400) begin
      both    = aw_seen && w_seen;
      awready = (cyc >= aw_delay);
      wready  = (cyc >= w_delay);
      bvalid  = both && (bwait >= b_delay);
      bresp   = br;
      bid     = bad_bid ? (MID ^ 4'h3) : MID;
      #1;
      aw_now = 0; w_now = 0;
      if (cyc == 0) begin
        check("awvalid_t1", awvalid, 1);
        check("wvalid_t1", wvalid, 1);
      end
      if (aw_seen) check("awvalid_dropped", awvalid, 0);
      else begin
        check("awvalid_held", awvalid, 1);
        if (awready) begin
          check("awaddr", awaddr, a);
          check("awlen", awlen, 0);
          check("awsize", awsize, 3'd2);
          check("awburst", awburst, 2'b01);
          check("awid", awid, MID);
          aw_now = 1;
        end
      end
      if (w_seen) check("wvalid_dropped", wvalid, 0);
      else begin
        check("wvalid_held", wvalid, 1);
        if (wready) begin
          check("wdata", wdata, d);
          check("wstrb", wstrb, s);
          check("wlast", wlast, 1);
          w_now = 1;
        end
      end
      if (both) begin
        check("bready", bready, 1);
        if (bvalid) begin
          check("wr_done_pulse", wr_done, 1);
          check("wr_err", wr_err, (br != 2'b00));
          done = 1;
        end else begin
          check("wr_done_idle", wr_done, 0);
        end
        bwait++;
      end else begin
        check("wr_done_early", wr_done, 0);
      end
      if (aw_now) aw_seen = 1;
      if (w_now)  w_seen = 1;
      @(negedge clk);
      cyc++;
    end
    if (!done) check("write_timeout", 0, 1);
    bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    #1;
    check("req_ready_after_write", req_ready, 1);
    check("wr_done_cleared", wr_done, 0);
    check("proto_err_write", proto_err, model_perr);
  endtask

  // Stimulus and final report
  initial begin
    rst = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_len = 0; req_wdata = 0; req_wstrb = 0;
    rsp_ready = 1; arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_bready", bready, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_proto_err", proto_err, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed scenarios
    do_read(32'h0000_2000, 4'd3, 1, 3, 0, 0, 0);
    do_write(32'h0000_1000, 32'hcafe_f00d, 4'b0011, 3, 0, 1, 2'b00, 0);
    do_read(32'h0000_3000, 4'd3, 0, 3, 0, 1, 0);
    do_write(32'h0000_1040, 32'h1234_5678, 4'b1111, 0, 2, 0, 2'b10, 0);
    do_write(32'h0000_1080, 32'h0bad_beef, 4'b0101, 1, 1, 2, 2'b00, 0);
    do_read(32'h0000_5000, 4'd15, 2, 15, 0, 2, 1);
    do_read(32'h0000_5100, 4'd0, 0, 0, 0, 0, 0);

    // Randomized mix of well-formed transactions
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [3:0] l;
        l = 4'($urandom_range(0, 15));
        do_read($urandom() & 32'hffff_fffc, l, $urandom_range(0, 3), int'(l), 0, 2, 1);
      end else begin
        do_write($urandom() & 32'hffff_fffc, $urandom(), 4'($urandom()),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 2'($urandom_range(0, 3)), 0);
      end
    end

    // Protocol violations: early RLAST, late RLAST, bad RID, bad BID
    do_read(32'h0000_6000, 4'd3, 0, 2, 0, 0, 0);
    do_read(32'h0000_6100, 4'd1, 0, 3, 0, 2, 1);
    do_read(32'h0000_6200, 4'd2, 1, 2, 1, 0, 0);
    do_write(32'h0000_6300, 32'h5555_aaaa, 4'b1000, 0, 0, 0, 2'b00, 1);

    // Reset while ARVALID is held high
    accept_req(1'b0, 32'h0000_7000, 4'd3, 0, 0);
    arready = 1'b0;
    @(negedge clk);
    #1;
    check("arvalid_before_reset", arvalid, 1);
    #2;
    rst = 1'b0;
    #1;
    model_perr = 0;
    check("arvalid_async_reset", arvalid, 0);
    check("req_ready_async_reset", req_ready, 1);
    check("proto_err_cleared", proto_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_read(32'h0000_7800, 4'd3, 1, 3, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
